pixel_fetch_engine: RTL

Upstream stage of the VGA refresh engine. Streams 12-bit RGB444 pixels out of framebuffer memory, starting at the framebuffer base address, using a request/ack/read-valid handshake. Buffers the pixels in a show-ahead FIFO. Presents the FIFO head on current_pixel and pops one pixel per cycle while active_video is high. Frame restart is driven by en_fetching from the refresh engine.

---
 rtl/pixel_fetch_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pixel_fetch_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_fetch_engine                                                       |
// | Streams RGB444 framebuffer pixels into a show-ahead FIFO for the VGA      |
// | refresh engine. Optional macro FETCH_UNDERFLOW_CNT_EN adds                |
// | underflow_count and a magenta starvation pixel.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_fetch_engine #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en_fetching,
  input  logic              active_video,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rd_valid,
  input  logic [11:0]       mem_rd_data,
  output logic [11:0]       current_pixel,
  output logic              underflow,
`ifdef FETCH_UNDERFLOW_CNT_EN
  output logic [15:0]       underflow_count,
`endif
  output logic              frame_done
);

  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [ADDR_W:0]   C_TOTAL = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
`ifdef FETCH_UNDERFLOW_CNT_EN
  localparam logic [11:0] C_UF_PIX = 12'hF0F;
`else
  localparam logic [11:0] C_UF_PIX = 12'h000;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [11:0]         r_fifo [FIFO_DEPTH];
  logic [C_PTR_W-1:0]  r_wptr, r_rptr;
  logic [C_CNT_W-1:0]  r_count, r_outst, w_count_nxt, w_outst_nxt;
  logic [ADDR_W-1:0]   r_addr, r_req_cnt;
  logic [ADDR_W:0]     w_req_cnt_nxt;
  logic                r_req, w_req_nxt, r_uflow, r_done;
  logic                w_restart, w_ack, w_rd_take, w_push, w_pop, w_uf_evt, w_credit;

  always_comb begin
    w_restart = !en_fetching && (r_state != S_IDLE);
    w_ack     = r_req && mem_ack;
    // Returns are only consumed against a live outstanding credit.
    w_rd_take = mem_rd_valid && (r_state != S_IDLE) && (r_outst != '0);
    w_push    = w_rd_take && ((r_state == S_FETCH) || (r_state == S_DONE)) && !w_restart;
    w_pop     = active_video && (r_count != '0);
    w_uf_evt  = active_video && (r_count == '0);

    w_count_nxt   = w_restart ? '0 : r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
    w_outst_nxt   = r_outst + C_CNT_W'(w_ack) - C_CNT_W'(w_rd_take);
    w_req_cnt_nxt = w_restart ? '0 : {1'b0, r_req_cnt} + (ADDR_W+1)'(w_ack);
    w_credit      = ({1'b0, w_count_nxt} + {1'b0, w_outst_nxt}) < (C_CNT_W+1)'(FIFO_DEPTH);

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en_fetching) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_restart) w_state_nxt = S_FLUSH;
        else if (w_req_cnt_nxt == C_TOTAL) w_state_nxt = S_DONE;
      end
      S_DONE:  if (w_restart) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_outst == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A pending request is held until acked; a new one needs credit.
    w_req_nxt = (w_state_nxt == S_FETCH) &&
                ((r_req && !mem_ack) || (w_credit && (w_req_cnt_nxt < C_TOTAL)));
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= C_BASE;
      r_req_cnt <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_uflow   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_count <= w_count_nxt;
      r_outst <= w_outst_nxt;
      if (w_restart) begin
        r_addr    <= C_BASE;
        r_req_cnt <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_uflow   <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        if (w_ack) begin
          r_addr    <= r_addr + ADDR_W'(1);
          r_req_cnt <= w_req_cnt_nxt[ADDR_W-1:0];
        end
        if (w_push)   r_wptr  <= r_wptr + C_PTR_W'(1);
        if (w_pop)    r_rptr  <= r_rptr + C_PTR_W'(1);
        if (w_uf_evt) r_uflow <= 1'b1;
        if ((r_state == S_FETCH) && (w_state_nxt == S_DONE)) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= mem_rd_data;
  end

`ifdef FETCH_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;
  always_ff @(posedge clk) begin
    if (!rst_ || w_restart) r_uf_cnt <= '0;
    else if (w_uf_evt && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 16'd1;
  end
  assign underflow_count = r_uf_cnt;
`endif

  assign mem_req       = r_req;
  assign mem_addr      = r_addr;
  assign underflow     = r_uflow;
  assign frame_done    = r_done;
  assign current_pixel = (r_count != '0) ? r_fifo[r_rptr] : (active_video ? C_UF_PIX : 12'h000);

endmodule
`default_nettype wire
